// File: rtl/repne_sequencer_ex.sv
// repne_sequencer_ex: multi-cycle REP/REPNE string-op sequencer for the execute stage.
// Steps CMPS through alternating first/second uops and other string ops through
// a repeating steady-state uop. It decrements CX/ECX each iteration and stops on
// count exhaustion or (CMPS only) on the ZF condition.
// Optional feature macro: REPE_EN. When defined, is_repe selects REPE semantics
// (terminate on ZF=0). When undefined, every CMPS repeat terminates on ZF=1.
module repne_sequencer_ex #(
  parameter int unsigned COUNT_W = 32,
  parameter int unsigned ZF_BIT  = 6
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               EX_V,
  input  logic               rep_start,
  input  logic               is_cmps,
  input  logic               is_repe,
  input  logic [1:0]         datasize,
  input  logic [COUNT_W-1:0] count_in,
  input  logic [31:0]        flags_in,
  input  logic               WB_stall,
  input  logic               flush,
  output logic               uop_first,
  output logic               uop_second,
  output logic               steady_state,
  output logic [COUNT_W-1:0] count_out,
  output logic               ld_count,
  output logic               terminate,
  output logic               ex_stall,
  output logic               busy
);

  localparam int unsigned CX_W = 16;

  // Mask covering the CX portion of the count register.
  localparam logic [COUNT_W-1:0] LOW_MASK = COUNT_W'({CX_W{1'b1}});
  localparam logic [COUNT_W-1:0] ONE      = COUNT_W'(1);

  localparam logic [1:0] DS_16 = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMPS1  = 3'd1,
    S_CMPS2  = 3'd2,
    S_STEADY = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [COUNT_W-1:0]   count_q;
  logic [COUNT_W-1:0]   count_d;
  logic                 mode16_q;
  logic                 mode16_d;
  logic                 dec_fire;

  logic                 start_mode16;
  logic                 start_zero;
  logic [COUNT_W-1:0]   count_dec;
  logic                 dec_zero;
  logic                 zf;
  logic                 zf_term;

  logic                 uop_first_d;
  logic                 uop_second_d;
  logic                 steady_state_d;
  logic                 ld_count_d;
  logic                 terminate_d;
  logic                 ex_stall_d;
  logic                 busy_d;

  // Width selection and zero test for the count presented at start.
  assign start_mode16 = (datasize == DS_16);
  assign start_zero   = start_mode16 ? ((count_in & LOW_MASK) == '0) : (count_in == '0);

  // Decrement only the active width; in 16-bit mode the upper bits are kept.
  assign count_dec = mode16_q ? ((count_q & ~LOW_MASK) | ((count_q - ONE) & LOW_MASK))
                              : (count_q - ONE);
  assign dec_zero  = mode16_q ? ((count_dec & LOW_MASK) == '0) : (count_dec == '0);

  assign zf = flags_in[ZF_BIT];

`ifdef REPE_EN
  logic repe_q;
  logic repe_d;

  // REPE stops when ZF clears, REPNE stops when ZF sets.
  assign zf_term = (zf == !repe_q);
`else
  // Only ZF participates; the REPE prefix is not honoured in this build.
  assign zf_term = zf;
`endif

  // Flag bits other than ZF (and is_repe when unused) are intentionally ignored.
`ifdef REPE_EN
  logic unused_flags;
  assign unused_flags = ^{flags_in[31:0]};
`else
  logic unused_flags;
  assign unused_flags = ^{flags_in[31:0], is_repe};
`endif

  // State and iteration datapath registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mode16_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mode16_q <= mode16_d;
    end
  end

`ifdef REPE_EN
  // Prefix flavour captured with the starting uop.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      repe_q <= 1'b0;
    end else begin
      repe_q <= repe_d;
    end
  end
`endif

  // Next-state and count update; flush beats advance, WB_stall freezes everything.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode16_d = mode16_q;
    dec_fire = 1'b0;
`ifdef REPE_EN
    repe_d   = repe_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else if (!WB_stall) begin
      case (state_q)
        S_IDLE: begin
          if (EX_V && rep_start) begin
            mode16_d = start_mode16;
`ifdef REPE_EN
            repe_d   = is_repe;
`endif
            if (start_zero) begin
              state_d = S_DONE;
            end else begin
              count_d = count_in;
              state_d = is_cmps ? S_CMPS1 : S_STEADY;
            end
          end
        end
        S_CMPS1: begin
          state_d = S_CMPS2;
        end
        S_CMPS2: begin
          dec_fire = 1'b1;
          count_d  = count_dec;
          state_d  = (dec_zero || zf_term) ? S_DONE : S_CMPS1;
        end
        S_STEADY: begin
          dec_fire = 1'b1;
          count_d  = count_dec;
          state_d  = dec_zero ? S_DONE : S_STEADY;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output is a flop aligned with state.
  always_comb begin
    uop_first_d    = 1'b0;
    uop_second_d   = 1'b0;
    steady_state_d = 1'b0;
    terminate_d    = 1'b0;
    ex_stall_d     = 1'b0;
    busy_d         = (state_d != S_IDLE);
    ld_count_d     = dec_fire;
    case (state_d)
      S_CMPS1: begin
        uop_first_d = 1'b1;
        ex_stall_d  = 1'b1;
      end
      S_CMPS2: begin
        uop_second_d = 1'b1;
        ex_stall_d   = 1'b1;
      end
      S_STEADY: begin
        steady_state_d = 1'b1;
        ex_stall_d     = 1'b1;
      end
      S_DONE: begin
        terminate_d = 1'b1;
      end
      default: begin
        busy_d = (state_d != S_IDLE);
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      uop_first    <= 1'b0;
      uop_second   <= 1'b0;
      steady_state <= 1'b0;
      ld_count     <= 1'b0;
      terminate    <= 1'b0;
      ex_stall     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      uop_first    <= uop_first_d;
      uop_second   <= uop_second_d;
      steady_state <= steady_state_d;
      ld_count     <= ld_count_d;
      terminate    <= terminate_d;
      ex_stall     <= ex_stall_d;
      busy         <= busy_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: tb/tb_repne_sequencer_ex.sv
// Testbench for repne_sequencer_ex: directed scenarios plus randomized string ops,
// checked against a transaction-level model (iteration count from the count/ZF
// rules, expected uop sequence as a queue, stalls replayed as "hold" cycles).
`timescale 1ns/1ps
module tb_repne_sequencer_ex;

  localparam int unsigned COUNT_W = 32;
  localparam int unsigned ZF_BIT  = 6;
  localparam int          MAX_CYC = 200;
`ifdef REPE_EN
  localparam bit REPE_ON = 1'b1;
`else
  localparam bit REPE_ON = 1'b0;
`endif

  localparam int K_IDLE   = 0;
  localparam int K_FIRST  = 1;
  localparam int K_SECOND = 2;
  localparam int K_STEADY = 3;
  localparam int K_DONE   = 4;
  localparam int K_BAD    = 7;

  logic               CLK;
  logic               CLR;
  logic               EX_V;
  logic               rep_start;
  logic               is_cmps;
  logic               is_repe;
  logic [1:0]         datasize;
  logic [COUNT_W-1:0] count_in;
  logic [31:0]        flags_in;
  logic               WB_stall;
  logic               flush;
  logic               uop_first;
  logic               uop_second;
  logic               steady_state;
  logic [COUNT_W-1:0] count_out;
  logic               ld_count;
  logic               terminate;
  logic               ex_stall;
  logic               busy;

  int                 n_vec;
  int                 n_err;
  logic [COUNT_W-1:0] mdl_count;

  repne_sequencer_ex #(.COUNT_W(COUNT_W), .ZF_BIT(ZF_BIT)) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .EX_V         (EX_V),
    .rep_start    (rep_start),
    .is_cmps      (is_cmps),
    .is_repe      (is_repe),
    .datasize     (datasize),
    .count_in     (count_in),
    .flags_in     (flags_in),
    .WB_stall     (WB_stall),
    .flush        (flush),
    .uop_first    (uop_first),
    .uop_second   (uop_second),
    .steady_state (steady_state),
    .count_out    (count_out),
    .ld_count     (ld_count),
    .terminate    (terminate),
    .ex_stall     (ex_stall),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which uop the outputs announce; more than one active is reported as K_BAD.
  function automatic int obs_kind();
    int hits;
    hits = int'(uop_first) + int'(uop_second) + int'(steady_state) + int'(terminate);
    if (hits > 1) return K_BAD;
    if (uop_first) return K_FIRST;
    if (uop_second) return K_SECOND;
    if (steady_state) return K_STEADY;
    if (terminate) return K_DONE;
    return K_IDLE;
  endfunction

  task automatic check_cycle(input string tag, input int exp_kind, input bit exp_ld);
    bit exp_stall;
    exp_stall = (exp_kind == K_FIRST) || (exp_kind == K_SECOND) || (exp_kind == K_STEADY);
    check({tag, ".kind"},  64'(obs_kind()), 64'(exp_kind));
    check({tag, ".ld"},    64'(ld_count),   64'(exp_ld));
    check({tag, ".cnt"},   64'(count_out),  64'(mdl_count));
    check({tag, ".stall"}, 64'(ex_stall),   64'(exp_stall));
    check({tag, ".busy"},  64'(busy),       64'(exp_kind != K_IDLE));
  endtask

  task automatic drive_idle();
    EX_V      = 1'b0;
    rep_start = 1'b0;
    is_cmps   = 1'b0;
    is_repe   = 1'b0;
    datasize  = 2'b00;
    count_in  = '0;
    flags_in  = '0;
    WB_stall  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rst_out"}, 64'({uop_first, uop_second, steady_state, ld_count,
                                  terminate, ex_stall, busy}), 64'(0));
    check({tag, ".rst_cnt"}, 64'(count_out), 64'(0));
  endtask

  // One idle cycle with a start attempt that must not be accepted.
  task automatic idle_cycle();
    int sel;
    sel       = int'($urandom_range(2));
    EX_V      = 1'b1;
    rep_start = (sel != 0);
    WB_stall  = (sel == 1);
    flush     = (sel == 2);
    is_cmps   = 1'($urandom_range(1));
    datasize  = 2'b10;
    count_in  = 32'($urandom_range(9, 1));
    flags_in  = $urandom;
    @(posedge CLK);
    #1;
    check_cycle("idle", K_IDLE, 1'b0);
    drive_idle();
  endtask

  // Issue one REP string op and follow it to completion, flush or reset.
  // zf_bits[i] is ZF presented on the i-th CMPS second uop; stall_mask[c] forces a
  // WB stall after observing cycle c; flush_at/reset_at are cycle indices (-1 = none).
  task automatic run_txn(input string tag, input bit cmps, input bit repe,
                         input logic [1:0] ds, input logic [31:0] cnt,
                         input logic [31:0] zf_bits, input logic [31:0] stall_mask,
                         input int stall_pct, input int flush_at, input int reset_at);
    bit   m16;
    bit   term_val;
    bit   found;
    int   n;
    int   iters;
    int   kinds[$];
    int   idx;
    int   decs;
    int   cyc;
    int   exp_kind;
    int   prev_kind;
    bit   exp_ld;
    bit   prev_hold;
    bit   flushed;
    bit   stall;
    bit   flush_now;
    bit   fin;

    m16      = (ds == 2'b01);
    n        = m16 ? int'(cnt[15:0]) : int'(cnt);
    term_val = REPE_ON ? !repe : 1'b1;
    iters    = n;
    found    = 1'b0;
    if (cmps) begin
      for (int i = 0; i < n && i < 32; i++) begin
        if (!found && zf_bits[i] == term_val) begin
          iters = i + 1;
          found = 1'b1;
        end
      end
    end
    kinds.delete();
    for (int i = 0; i < iters; i++) begin
      if (cmps) begin
        kinds.push_back(K_FIRST);
        kinds.push_back(K_SECOND);
      end else begin
        kinds.push_back(K_STEADY);
      end
    end
    kinds.push_back(K_DONE);

    EX_V      = 1'b1;
    rep_start = 1'b1;
    is_cmps   = cmps;
    is_repe   = repe;
    datasize  = ds;
    count_in  = cnt;
    WB_stall  = 1'b0;
    flush     = 1'b0;
    flags_in  = $urandom;

    prev_kind = K_IDLE;
    prev_hold = 1'b0;
    flushed   = 1'b0;
    idx       = 0;
    decs      = 0;
    cyc       = 0;
    fin       = 1'b0;
    while (!fin) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (flushed) begin
        exp_kind = K_IDLE;
      end else if (prev_hold) begin
        exp_kind = prev_kind;
      end else begin
        exp_kind = (idx < kinds.size()) ? kinds[idx] : K_IDLE;
        idx++;
      end
      exp_ld = !flushed && !prev_hold && (prev_kind == K_SECOND || prev_kind == K_STEADY);
      if (cyc == 1 && n != 0) mdl_count = cnt;
      if (exp_ld) begin
        decs++;
        mdl_count = m16 ? {cnt[31:16], 16'(cnt[15:0] - 16'(decs))} : (cnt - 32'(decs));
      end
      check_cycle(tag, exp_kind, exp_ld);

      if (exp_kind == K_IDLE) begin
        fin = 1'b1;
      end else if (cyc >= MAX_CYC) begin
        check({tag, ".timeout"}, 64'(1), 64'(0));
        fin = 1'b1;
      end else if (cyc == reset_at) begin
        CLR = 1'b0;
        #1;
        check_reset_outputs(tag);
        mdl_count = '0;
        #1;
        CLR = 1'b1;
        fin = 1'b1;
      end else begin
        stall     = (cyc < 32 && stall_mask[cyc]) || (int'($urandom_range(99)) < stall_pct);
        flush_now = (cyc == flush_at);
        WB_stall  = stall;
        flush     = flush_now;
        EX_V      = 1'($urandom_range(1));
        rep_start = 1'($urandom_range(1));
        is_cmps   = 1'($urandom_range(1));
        is_repe   = 1'($urandom_range(1));
        datasize  = 2'($urandom_range(3));
        count_in  = $urandom;
        flags_in  = $urandom;
        if (exp_kind == K_SECOND && decs < 32) flags_in[ZF_BIT] = zf_bits[decs];
        prev_kind = exp_kind;
        prev_hold = stall;
        flushed   = flush_now;
      end
    end
    drive_idle();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    mdl_count = '0;
    CLR       = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b1;
    idle_cycle();

    run_txn("cmps_ecx3",    1'b1, 1'b0, 2'b10, 32'd3,          32'h0, 32'h0,  0, -1, -1);
    run_txn("cmps_zf_it2",  1'b1, 1'b0, 2'b10, 32'd5,          32'h2, 32'h0,  0, -1, -1);
    run_txn("stos_cx16",    1'b0, 1'b0, 2'b01, 32'h1234_0002,  32'h0, 32'h0,  0, -1, -1);
    run_txn("ecx_zero",     1'b1, 1'b0, 2'b10, 32'd0,          32'h0, 32'h0,  0, -1, -1);
    run_txn("stall_cmps2",  1'b1, 1'b0, 2'b10, 32'd1,          32'h0, 32'h1C, 0, -1, -1);
    run_txn("flush_cmps1",  1'b1, 1'b0, 2'b10, 32'd3,          32'h0, 32'h0,  0,  1, -1);
    run_txn("repe_ecx4",    1'b1, 1'b1, 2'b10, 32'd4,          32'h0, 32'h0,  0, -1, -1);
    run_txn("zf_and_zero",  1'b1, 1'b0, 2'b10, 32'd2,          32'h2, 32'h0,  0, -1, -1);
    run_txn("ds11_steady",  0,    1'b0, 2'b11, 32'd3,          32'h0, 32'h0,  0, -1, -1);
    run_txn("ds00_steady",  0,    1'b0, 2'b00, 32'd2,          32'h0, 32'h0,  0, -1, -1);
    run_txn("cx16_hi_zero", 1'b0, 1'b0, 2'b01, 32'hABCD_0000,  32'h0, 32'h0,  0, -1, -1);
    run_txn("ecx_hi_only",  1'b0, 1'b0, 2'b10, 32'h0001_0000,  32'h0, 32'h0,  0,  3, -1);
    run_txn("stall_done",   1'b0, 1'b0, 2'b10, 32'd1,          32'h0, 32'h6,  0, -1, -1);
    run_txn("rst_mid",      1'b0, 1'b0, 2'b10, 32'd6,          32'h0, 32'h0,  0, -1,  3);
    idle_cycle();

    for (int t = 0; t < 60; t++) begin
      bit          c;
      bit          r;
      logic [1:0]  ds;
      logic [31:0] cnt;
      logic [31:0] zf;
      int          n;
      int          fa;
      int          ra;
      c   = 1'($urandom_range(1));
      r   = 1'($urandom_range(1));
      ds  = 2'($urandom_range(3));
      n   = int'($urandom_range(10));
      cnt = (ds == 2'b01) ? {16'($urandom), 16'(n)} : 32'(n);
      zf  = $urandom & $urandom & $urandom;
      fa  = (int'($urandom_range(9)) == 0) ? int'($urandom_range(2 * n + 1, 1)) : -1;
      ra  = (int'($urandom_range(19)) == 0) ? int'($urandom_range(3, 1)) : -1;
      run_txn($sformatf("rnd%0d", t), c, r, ds, cnt, zf, 32'h0, 25, fa, ra);
      repeat (int'($urandom_range(2))) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
